// File: rtl/wbm_pkg.sv
// wbm_pkg: shared definitions for the Wishbone single-transfer master.
//   wbm_state_e  - controller states (IDLE, BUS, RESP)
//   WBM_*        - response status codes returned on rsp_status_o
//   ctr_width()  - width of the timeout counter for a given limit
package wbm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_e;

    localparam logic [1:0] WBM_OK      = 2'b00;
    localparam logic [1:0] WBM_ERR     = 2'b01;
    localparam logic [1:0] WBM_TIMEOUT = 2'b10;

    // Enough bits to hold 0..t, never narrower than one bit (t = 0 is legal).
    function automatic int ctr_width(input int t);
        int w;
        w = $clog2(t + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wbm_timeout_ctr.sv
// wbm_timeout_ctr: saturating cycle counter that flags when a bus cycle has
// been waiting for TIMEOUT_CYCLES clocks.
//   clk, rst  - clock, asynchronous active-high reset (counter -> 0)
//   en        - count this cycle (controller is in BUS)
//   clr       - clear the count (transfer terminated); wins over en
//   expired   - count has reached TIMEOUT_CYCLES-1, i.e. this is the last
//               cycle CYC may stay high; never asserted when TIMEOUT_CYCLES=0
module wbm_timeout_ctr
    import wbm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = ctr_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);
    // Holding at TIMEOUT_CYCLES keeps the count from wrapping back into range.
    localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != SAT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/wbm_single_master.sv
// wbm_single_master: Wishbone classic initiator that runs exactly one
// single-beat cycle per command and returns data plus status.
//   wb_clk_i, wb_rst_i          - clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o   - command handshake (we, adr, dat, sel)
//   rsp_valid_o / rsp_ready_i   - response handshake (rsp_dat_o, rsp_status_o)
//   wbm_*                       - Wishbone master side (CYC, STB, WE, SEL, ADR,
//                                 DAT out/in, ACK, ERR)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload stable until that edge;
// ready never depends combinationally on valid (all outputs are registered).
//
// Every output is a flop. The current state is held in `state` (wbm_state_e)
// for observation. Response data is zero for writes, bus errors and timeouts.
module wbm_single_master
    import wbm_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int BYTE_EN_WIDTH  = BUS_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [BYTE_EN_WIDTH-1:0]  cmd_sel_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [BUS_DATA_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]                rsp_status_o,

    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic                      wbm_we_o,
    output logic [BYTE_EN_WIDTH-1:0]  wbm_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i
);

    wbm_state_e state;
    logic       expired;
    logic       bus_term;

    // ACK/ERR only matter while a cycle is open; outside BUS they are ignored.
    assign bus_term = (state == BUS) && (wbm_err_i || wbm_ack_i || expired);

    wbm_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .en      (state == BUS),
        .clr     (bus_term),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= WBM_OK;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_sel_o    <= '0;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready_o rises on the first edge after reset release.
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        wbm_we_o    <= cmd_we_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        state       <= BUS;
                    end
                end

                BUS: begin
                    if (bus_term) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                        // ERR outranks a simultaneous ACK.
                        if (wbm_err_i) begin
                            rsp_status_o <= WBM_ERR;
                            rsp_dat_o    <= '0;
                        end else if (wbm_ack_i) begin
                            rsp_status_o <= WBM_OK;
                            rsp_dat_o    <= wbm_we_o ? '0 : wbm_dat_i;
                        end else begin
                            rsp_status_o <= WBM_TIMEOUT;
                            rsp_dat_o    <= '0;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_single_master.sv
// tb_wbm_single_master: directed bench for wbm_single_master with
// TIMEOUT_CYCLES=16, 32-bit data, 8-bit address. The Wishbone slave is played
// directly from the stimulus sequence by driving ACK/ERR/DAT on chosen cycles.
module tb_wbm_single_master;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic          wbm_cyc;
    logic          wbm_stb;
    logic          wbm_we;
    logic [SW-1:0] wbm_sel;
    logic [AW-1:0] wbm_adr;
    logic [DW-1:0] wbm_dat_out;
    logic [DW-1:0] wbm_dat_in = '0;
    logic          wbm_ack = 1'b0;
    logic          wbm_err = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    wbm_single_master #(
        .BUS_DATA_WIDTH (DW),
        .BUS_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_dat_i    (cmd_dat),
        .cmd_sel_i    (cmd_sel),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_dat_o    (rsp_dat),
        .rsp_status_o (rsp_status),
        .wbm_cyc_o    (wbm_cyc),
        .wbm_stb_o    (wbm_stb),
        .wbm_we_o     (wbm_we),
        .wbm_sel_o    (wbm_sel),
        .wbm_adr_o    (wbm_adr),
        .wbm_dat_o    (wbm_dat_out),
        .wbm_dat_i    (wbm_dat_in),
        .wbm_ack_i    (wbm_ack),
        .wbm_err_i    (wbm_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    // Advance to just after the next rising edge; all drives and checks
    // happen here, 1 time unit past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge (caller guarantees cmd_ready=1).
    task automatic issue(input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Count cycles with CYC high, starting just after the accept edge.
    task automatic count_cyc(output int n);
        n = 0;
        while (wbm_cyc === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    int cyc_hi;

    initial begin
        // --- asynchronous reset, checked before any clock edge ---
        #1 rst = 1'b1;
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cyc", wbm_cyc, 0);
        check("rst_stb", wbm_stb, 0);
        tick();
        tick();
        check("rst_held_ready", cmd_ready, 0);
        rst = 1'b0;
        tick();
        check("ready_after_release", cmd_ready, 1);
        check("idle_cyc", wbm_cyc, 0);

        rsp_ready = 1'b1;

        // --- write EEEEEEEE to 0x04, immediate ACK ---
        issue(1'b1, 8'h04, 32'hEEEEEEEE, 4'hF);
        check("wr_cyc", wbm_cyc, 1);
        check("wr_stb", wbm_stb, 1);
        check("wr_we", wbm_we, 1);
        check("wr_adr", wbm_adr, 8'h04);
        check("wr_dat", wbm_dat_out, 32'hEEEEEEEE);
        check("wr_sel", wbm_sel, 4'hF);
        check("wr_cmd_ready", cmd_ready, 0);
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check("wr_cyc_one_cycle", wbm_cyc, 0);
        check("wr_we_dropped", wbm_we, 0);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_status", rsp_status, 2'b00);
        check("wr_rsp_dat", rsp_dat, 0);
        tick();
        check("wr_rsp_consumed", rsp_valid, 0);
        check("wr_back_ready", cmd_ready, 1);

        // --- read back 0x04, immediate ACK with stored data ---
        issue(1'b0, 8'h04, 32'h0, 4'hF);
        check("rd_cyc", wbm_cyc, 1);
        check("rd_we", wbm_we, 0);
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'hEEEEEEEE;
        tick();
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'h0;
        check("rd_cyc_one_cycle", wbm_cyc, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_status", rsp_status, 2'b00);
        check("rd_rsp_dat", rsp_dat, 32'hEEEEEEEE);
        tick();
        check("rd_back_ready", cmd_ready, 1);

        // --- slow slave: ACK sampled 3 edges after the accept edge ---
        issue(1'b0, 8'h10, 32'h0, 4'h5);
        for (int i = 0; i < 3; i++) begin
            check("slow_cyc", wbm_cyc, 1);
            check("slow_adr", wbm_adr, 8'h10);
            check("slow_sel", wbm_sel, 4'h5);
            check("slow_no_rsp", rsp_valid, 0);
            if (i == 2) begin
                wbm_ack    = 1'b1;
                wbm_dat_in = 32'hDEADBEEF;
            end
            tick();
        end
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'h0;
        check("slow_rsp_valid", rsp_valid, 1);
        check("slow_status", rsp_status, 2'b00);
        check("slow_rsp_dat", rsp_dat, 32'hDEADBEEF);
        tick();
        check("slow_back_ready", cmd_ready, 1);

        // --- no ACK at all: timeout after exactly 16 cycles of CYC ---
        wbm_dat_in = 32'h12345678;
        issue(1'b0, 8'h20, 32'h0, 4'hF);
        count_cyc(cyc_hi);
        check("to_cyc_cycles", cyc_hi, 16);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_status", rsp_status, 2'b10);
        check("to_rsp_dat", rsp_dat, 0);
        tick();
        check("to_rsp_consumed", rsp_valid, 0);
        // Late ACK two cycles after the timeout must be ignored.
        wbm_ack = 1'b1;
        tick();
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'h0;
        check("late_ack_no_rsp", rsp_valid, 0);
        check("late_ack_no_cyc", wbm_cyc, 0);
        check("late_ack_ready", cmd_ready, 1);

        // --- ERR and ACK together on a read: ERR wins ---
        issue(1'b0, 8'h30, 32'h0, 4'hF);
        wbm_ack    = 1'b1;
        wbm_err    = 1'b1;
        wbm_dat_in = 32'hAAAA5555;
        tick();
        wbm_ack    = 1'b0;
        wbm_err    = 1'b0;
        wbm_dat_in = 32'h0;
        check("err_rsp_valid", rsp_valid, 1);
        check("err_status", rsp_status, 2'b01);
        check("err_rsp_dat", rsp_dat, 0);
        check("err_cyc", wbm_cyc, 0);
        tick();
        check("err_back_ready", cmd_ready, 1);

        // --- response back-pressure for 5 cycles ---
        rsp_ready = 1'b0;
        issue(1'b0, 8'h38, 32'h0, 4'hF);
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'h0BADF00D;
        tick();
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_dat", rsp_dat, 32'h0BADF00D);
            check("bp_status", rsp_status, 2'b00);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_no_cyc", wbm_cyc, 0);
            if (i == 2) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_adr   = 8'h40;
                cmd_dat   = 32'h55555555;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        check("bp_released", rsp_valid, 0);
        check("bp_ready_again", cmd_ready, 1);
        check("bp_pulse_not_taken", wbm_cyc, 0);
        tick();
        check("bp_pulse_still_idle", wbm_cyc, 0);

        // --- reset during the second cycle of a slow transfer ---
        issue(1'b0, 8'h50, 32'h0, 4'hF);
        tick();
        check("mid_cyc_before_rst", wbm_cyc, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cyc", wbm_cyc, 0);
        check("mid_rst_stb", wbm_stb, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        tick();
        rst     = 1'b0;
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_no_rsp", rsp_valid, 0);
        check("post_rst_no_cyc", wbm_cyc, 0);
        tick();
        check("post_rst_no_stale", rsp_valid, 0);

        // --- a full timeout after the mid-transfer reset ---
        issue(1'b1, 8'h60, 32'h01020304, 4'h3);
        count_cyc(cyc_hi);
        check("to2_cyc_cycles", cyc_hi, 16);
        check("to2_status", rsp_status, 2'b10);
        check("to2_rsp_dat", rsp_dat, 0);
        tick();
        check("to2_back_ready", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wbm_single_master.md
Name: wbm_single_master

Overview:
Wishbone classic single-transfer master (initiator). It is the counterpart to our wbs_* slaves such as sys_block. It accepts one read or write command at a time on a valid/ready command port and runs exactly one Wishbone cycle (CYC/STB held until ACK, ERR or timeout). It returns the read data and a status on a valid/ready response port. It sits between a host-side command source (UART/Ethernet register bridge) and the board's Wishbone interconnect.

Parameters:
BUS_DATA_WIDTH, 32, data width (8, 16, 32, 64)
BUS_ADDR_WIDTH, 8, address width (4, 8, 16, 32)
BYTE_EN_WIDTH, BUS_DATA_WIDTH/8, select width (derived; do not override)
TIMEOUT_CYCLES, 16, maximum cycles CYC/STB stay high waiting for ACK/ERR; 0 disables the timeout

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  master idle, command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  BUS_ADDR_WIDTH  target address
cmd_dat_i  in  BUS_DATA_WIDTH  write data
cmd_sel_i  in  BYTE_EN_WIDTH  byte enables
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  BUS_DATA_WIDTH  read data (0 for writes and errors)
rsp_status_o  out  2  00 OK, 01 bus ERR, 10 TIMEOUT
wbm_cyc_o  out  1  Wishbone CYC
wbm_stb_o  out  1  Wishbone STB
wbm_we_o  out  1  Wishbone WE
wbm_sel_o  out  BYTE_EN_WIDTH  Wishbone SEL
wbm_adr_o  out  BUS_ADDR_WIDTH  Wishbone ADR
wbm_dat_o  out  BUS_DATA_WIDTH  Wishbone write data
wbm_dat_i  in  BUS_DATA_WIDTH  Wishbone read data
wbm_ack_i  in  1  Wishbone ACK
wbm_err_i  in  1  Wishbone ERR

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. All outputs 0, including cmd_ready_o, rsp_valid_o and wbm_cyc_o/stb_o. The timeout counter is 0.
- All outputs are registered.
- On the first edge after reset release, cmd_ready_o goes to 1.
- IDLE:
  - cmd_ready_o=1.
  - On valid&ready: latch we/adr/dat/sel into the wbm_* registers, and at the same edge set cyc=stb=1 and cmd_ready_o=0. Go to BUS.
  - CYC therefore rises on the edge that accepts the command.
- BUS:
  - cyc=stb=1 and wbm_* held stable.
  - The counter increments each cycle.
  - Termination is sampled each edge:
    - ERR=1: status=01, rsp_dat=0. ERR has priority over simultaneous ACK.
    - ACK=1: status=00. rsp_dat=wbm_dat_i for reads, 0 for writes.
    - Neither, TIMEOUT_CYCLES≠0 and the counter has reached TIMEOUT_CYCLES-1: status=10, rsp_dat=0. CYC is therefore high for exactly TIMEOUT_CYCLES cycles.
  - On termination, at the same edge: cyc=stb=0, wbm_we_o=0, rsp_valid_o=1, counter cleared. Go to RESP.
  - Fastest path: accept at edge N, ACK sampled at edge N+1, rsp_valid high after edge N+1.
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_status_o held until rsp_ready_i.
  - On valid&ready: rsp_valid_o=0, cmd_ready_o=1. Go to IDLE. The next command can be accepted one cycle later (no same-cycle bypass).
- ACK/ERR outside BUS are ignored (no state change, no response).
- A late ACK after a timeout is ignored.
- cmd_valid_i while not ready: no effect. The source must hold its data stable until accepted.
- Reset mid-transaction: the bus is released immediately and the pending command and response are discarded.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. The counter saturates and never wraps.
- No retries, no bursts (CTI/BTE not driven), at most one outstanding transfer.

Decomposition:
- Package wbm_pkg:
  - state encoding: IDLE=2'd0, BUS=2'd1, RESP=2'd2
  - status codes: WBM_OK=2'b00, WBM_ERR=2'b01, WBM_TIMEOUT=2'b10
- Sub-module wbm_timeout_ctr: parameter TIMEOUT_CYCLES; inputs clk, rst, en, clr; output expired. It holds the saturating counter and the disable-at-0 logic.
- The FSM and the data/response registers stay in wbm_single_master.

Test Plan:
- Write then read against a sys_block instance: write 32'hEEEEEEEE to 8'h04 with sel=4'hF, then read 8'h04. Required: write response status 00, rsp_dat 0; read response status 00, rsp_dat 32'hEEEEEEEE. CYC high 1 cycle per access when ACK is immediate.
- Slave model asserting ACK 3 cycles after STB, read returning 32'hDEADBEEF. Required: wbm_adr_o/sel stable for all 3 cycles, rsp_dat 32'hDEADBEEF, status 00.
- Slave never acks, TIMEOUT_CYCLES=16. Required: CYC high exactly 16 cycles, status 10, rsp_dat 0. An ACK injected 2 cycles later is ignored (no second rsp_valid).
- Slave asserts ERR and ACK in the same cycle on a read. Required: status 01, rsp_dat 0.
- rsp_ready_i held low 5 cycles. Required: rsp_valid_o/data/status stable for 5 cycles, cmd_ready_o stays 0, and a cmd_valid_i pulse in that window is not accepted.
- Assert wb_rst_i mid-BUS (cycle 2 of a slow transfer). Required: cyc/stb/rsp_valid drop to 0 without waiting for a clock edge, cmd_ready_o=1 one edge after release, no stale response emitted.
